scablk_wrfifo: RTL
==================

Name: scablk_wrfifo

Overview:
- Downstream stage of the SCA block-write controller.
- On every write strobe it captures which selection path fired and the SCA block number being written, and queues them in a FIFO for the readout sequencer.
- Generates the registered occupancy flags DSCAFULL/DLSCAFULL that feed back to the controller to throttle block writes.

Parameters:
- TMR, 0: 1 = triplicate state registers (pointers, count, flags) with majority voters.
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 entries (16).
- BLKW, 4: SCA block address width.
- MARGIN, 2: DSCAFULL asserts at count >= DEPTH-MARGIN; DLSCAFULL asserts at count >= DEPTH-MARGIN-1.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- WRENA  in  1  write strobe from block-write controller
- SELA  in  1  LCT-current path select
- SELB  in  1  no-L1-trigger path select
- SELC  in  1  second-block path select
- SELD  in  1  shared-second-block path select
- NOLCT  in  1  no-LCT (empty block) marker
- BLKADR  in  BLKW  SCA block being written this cycle
- RD_EN  in  1  read request from readout sequencer
- RD_DATA  out  3+BLKW  {tag[2:0], blk[BLKW-1:0]}
- RD_VLD  out  1  RD_DATA valid
- EMPTY  out  1  FIFO empty
- FULL  out  1  FIFO full
- DSCAFULL  out  1  near-full flag
- DLSCAFULL  out  1  earlier near-full flag
- COUNT  out  DEPTH_LOG2+1  occupancy
- OVFL  out  1  sticky overflow
- MSEL  out  1  sticky multiple-select error
- PAR_ERR  out  1  sticky parity error (see Optional Feature)

Behaviour:
- Reset (RST_N low, async): pointers and COUNT = 0, EMPTY = 1, FULL/DSCAFULL/DLSCAFULL = 0, RD_VLD = 0, RD_DATA = 0, OVFL/MSEL/PAR_ERR = 0. Reset mid-operation discards all queued entries.
- Tag encoding and priority when several selects are high: SELA=1 > SELB=2 > SELC=3 > SELD=4 > NOLCT=5. WRENA with no select high writes tag 0.
- MSEL sets when WRENA is high and more than one of SELA/SELB/SELC/SELD/NOLCT is high. The entry is still written using the priority tag.
- Push condition: WRENA & (!FULL | rd_ok), where rd_ok = RD_EN & !EMPTY.
- Pop condition: rd_ok. RD_EN while EMPTY is ignored; RD_VLD stays 0 and no error is flagged.
- Simultaneous push and pop: COUNT unchanged, both pointers advance. At FULL this frees the slot in the same cycle, so the write is accepted. At EMPTY only the push takes effect.
- WRENA while FULL with no pop: entry dropped, OVFL set, pointers unchanged.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. COUNT is DEPTH_LOG2+1 bits and ranges 0..DEPTH.
- Read latency: RD_DATA and RD_VLD are registered and appear 1 cycle after an accepted RD_EN. RD_VLD is a single-cycle pulse per pop. RD_DATA holds its value otherwise.
- EMPTY, FULL, DSCAFULL and DLSCAFULL are registered from next-state COUNT, so they are valid the cycle after the push/pop that changes them. No combinational path from WRENA to any flag.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: SCAFIFO_PARITY_EN.
- Defined: each entry stores an extra even-parity bit over {tag, blk}. On pop the parity is recomputed; a mismatch sets PAR_ERR in the same cycle RD_VLD asserts. RAM width becomes 4+BLKW.
- Undefined: no parity bit is stored and PAR_ERR is tied 0.

Decomposition:
- Shared package scafifo_pkg holds:
  - tag localparams TAG_NONE=0, TAG_A=1, TAG_B=2, TAG_C=3, TAG_D=4, TAG_NOLCT=5
  - TAG_W=3
- One sub-module, scafifo_ram: simple dual-port RAM, synchronous write, registered read, parameterised width/depth. It is not triplicated; TMR applies only to control state.

Test Plan:
- Reset, then WRENA+SELA with BLKADR=5 -> COUNT=1, EMPTY=0 next cycle; RD_EN -> RD_VLD one cycle later, RD_DATA={3'd1,4'd5}, EMPTY=1.
- 14 pushes with MARGIN=2 -> DSCAFULL rises the cycle after push 14. DLSCAFULL rises after push 13. FULL=0.
- Fill to 16, push again with no read -> OVFL=1, COUNT=16, oldest entry unchanged. Then push+RD_EN together at FULL -> accepted, COUNT=16, OVFL still 1.
- WRENA with SELB and NOLCT both high, BLKADR=9 -> entry {2,9} queued, MSEL=1.
- 40 interleaved push/pop cycles across pointer wrap -> data read out in FIFO order, COUNT consistent with reference model. RD_EN on EMPTY -> no RD_VLD, no change.
- With SCAFIFO_PARITY_EN: force-corrupt a stored bit -> PAR_ERR=1 on its RD_VLD cycle. Without the macro: PAR_ERR constant 0.

Source files
------------

// File: rtl/scafifo_pkg.sv
// Shared tags and select helpers for the SCA block-write FIFO.
package scafifo_pkg;

    localparam int TAG_W = 3;

    localparam logic [TAG_W-1:0] TAG_NONE  = 3'd0;
    localparam logic [TAG_W-1:0] TAG_A     = 3'd1;
    localparam logic [TAG_W-1:0] TAG_B     = 3'd2;
    localparam logic [TAG_W-1:0] TAG_C     = 3'd3;
    localparam logic [TAG_W-1:0] TAG_D     = 3'd4;
    localparam logic [TAG_W-1:0] TAG_NOLCT = 3'd5;

    // Selects overlap in practice, so the encoding is strictly prioritised.
    function automatic logic [TAG_W-1:0] sel_tag(
        input logic a,
        input logic b,
        input logic c,
        input logic d,
        input logic n
    );
        if (a)      return TAG_A;
        else if (b) return TAG_B;
        else if (c) return TAG_C;
        else if (d) return TAG_D;
        else if (n) return TAG_NOLCT;
        else        return TAG_NONE;
    endfunction

    function automatic logic multi_sel(
        input logic a,
        input logic b,
        input logic c,
        input logic d,
        input logic n
    );
        logic [2:0] s;
        s = 3'(a) + 3'(b) + 3'(c) + 3'(d) + 3'(n);
        return s > 3'd1;
    endfunction

endpackage

// File: rtl/scablk_wrfifo_ram.sv
// Simple dual-port RAM for the write FIFO: sync write, registered read.
module scafifo_ram #(
    parameter int W  = 7,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read output holds between pops; same-address write returns old data.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/scablk_wrfifo.sv
// SCA block-write FIFO with registered occupancy flags and optional TMR.
// Optional entry parity is enabled by defining SCAFIFO_PARITY_EN.
module scablk_wrfifo
    import scafifo_pkg::*;
#(
    parameter int TMR        = 0,
    parameter int DEPTH_LOG2 = 4,
    parameter int BLKW       = 4,
    parameter int MARGIN     = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  WRENA,
    input  logic                  SELA,
    input  logic                  SELB,
    input  logic                  SELC,
    input  logic                  SELD,
    input  logic                  NOLCT,
    input  logic [BLKW-1:0]       BLKADR,
    input  logic                  RD_EN,
    output logic [TAG_W+BLKW-1:0] RD_DATA,
    output logic                  RD_VLD,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  DSCAFULL,
    output logic                  DLSCAFULL,
    output logic [DEPTH_LOG2:0]   COUNT,
    output logic                  OVFL,
    output logic                  MSEL,
    output logic                  PAR_ERR
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int EW    = TAG_W + BLKW;
`ifdef SCAFIFO_PARITY_EN
    localparam int DW    = EW + 1;
`else
    localparam int DW    = EW;
`endif
    localparam int SW    = 2 * AW + CW + 8;
    localparam logic [SW-1:0] RST_V = {(SW-8)'(0), 8'h80};

    logic [SW-1:0] st, st_n;
    logic [AW-1:0] wptr, rptr, wptr_n, rptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          empty, full, dsf, dlsf;
    logic          ovfl, msel, perr, vld;
    logic          empty_n, full_n, dsf_n, dlsf_n;
    logic          ovfl_n, msel_n, perr_n, vld_n;
    logic          rd_ok, push, par_hit;
    logic [EW-1:0] entry;
    logic [DW-1:0] wdata, ram_q;

    assign {wptr, rptr, cnt, empty, full, dsf, dlsf,
            ovfl, msel, perr, vld} = st;

    assign st_n = {wptr_n, rptr_n, cnt_n, empty_n, full_n, dsf_n,
                   dlsf_n, ovfl_n, msel_n, perr_n, vld_n};

    assign rd_ok = RD_EN & ~empty;
    assign push  = WRENA & (~full | rd_ok);
    assign entry = {sel_tag(SELA, SELB, SELC, SELD, NOLCT), BLKADR};

`ifdef SCAFIFO_PARITY_EN
    assign wdata   = {^entry, entry};
    assign par_hit = vld & (^ram_q);
    assign PAR_ERR = perr | par_hit;
`else
    assign wdata   = entry;
    assign par_hit = 1'b0;
    assign PAR_ERR = 1'b0;
`endif

    always_comb begin
        wptr_n  = push  ? wptr + AW'(1) : wptr;
        rptr_n  = rd_ok ? rptr + AW'(1) : rptr;
        cnt_n   = cnt + CW'(push) - CW'(rd_ok);
        empty_n = (cnt_n == '0);
        full_n  = (cnt_n == CW'(DEPTH));
        dsf_n   = (cnt_n >= CW'(DEPTH - MARGIN));
        dlsf_n  = (cnt_n >= CW'(DEPTH - MARGIN - 1));
        ovfl_n  = ovfl | (WRENA & ~push);
        msel_n  = msel
                | (WRENA & multi_sel(SELA, SELB, SELC, SELD, NOLCT));
        perr_n  = perr | par_hit;
        vld_n   = rd_ok;
    end

    generate
        if (TMR != 0) begin : g_tmr
            logic [SW-1:0] r0, r1, r2;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    r0 <= RST_V;
                    r1 <= RST_V;
                    r2 <= RST_V;
                end else begin
                    r0 <= st_n;
                    r1 <= st_n;
                    r2 <= st_n;
                end
            end
            assign st = (r0 & r1) | (r0 & r2) | (r1 & r2);
        end else begin : g_single
            logic [SW-1:0] r;
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) r <= RST_V;
                else        r <= st_n;
            end
            assign st = r;
        end
    endgenerate

    scafifo_ram #(
        .W  (DW),
        .AW (AW)
    ) u_ram (
        .CLK   (CLK),
        .RST_N (RST_N),
        .we    (push),
        .waddr (wptr),
        .wdata (wdata),
        .re    (rd_ok),
        .raddr (rptr),
        .rdata (ram_q)
    );

    assign RD_DATA   = ram_q[EW-1:0];
    assign RD_VLD    = vld;
    assign EMPTY     = empty;
    assign FULL      = full;
    assign DSCAFULL  = dsf;
    assign DLSCAFULL = dlsf;
    assign COUNT     = cnt;
    assign OVFL      = ovfl;
    assign MSEL      = msel;

endmodule
